// File: rtl/avmm_csr_responder_pkg.sv
// Shared constants and address helpers for the AVMM CSR responder.
// Register indices are word indices, not byte addresses.
package avmm_csr_responder_pkg;

  localparam int unsigned ID_IDX   = 0;
  localparam int unsigned WCNT_IDX = 1;

  // Word index of a byte address; lane_bits = log2(bytes per word).
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                             input int unsigned lane_bits);
    return byte_addr >> lane_bits;
  endfunction

endpackage

// File: rtl/avmm_rd_delay_line.sv
// Fixed-latency {valid, data} pipe carrying read responses back to the host.
// Data in a stage only moves with a valid beat, so the output data holds between responses.
module avmm_rd_delay_line #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic                  v_in;
      logic [DATA_WIDTH-1:0] d_in;
      logic                  v_reg;
      logic [DATA_WIDTH-1:0] d_reg;

      if (gi == 0) begin : g_head
        assign v_in = in_valid;
        assign d_in = in_data;
      end else begin : g_tail
        assign v_in = g_stage[gi-1].v_reg;
        assign d_in = g_stage[gi-1].d_reg;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else begin
          v_reg <= v_in;
          if (v_in) d_reg <= d_in;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].v_reg;
  assign out_data  = g_stage[DEPTH-1].d_reg;

endmodule

// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR agent: ID register, accepted-write counter and scratch registers,
// with programmable wait states, fixed read latency and an outstanding-read bound.
module avmm_csr_responder
  import avmm_csr_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_REGS     = 16,
  parameter int                    READ_LATENCY = 2,
  parameter int                    WAIT_CYCLES  = 0,
  parameter int                    MAX_PENDING  = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'hA7C0_0001,
  parameter logic [DATA_WIDTH-1:0] BAD_DATA     = 32'hBADA_DD00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    avs_write,
  input  logic                    avs_read,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  output logic                    avs_waitrequest,
  output logic                    avs_readdatavalid,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    err_oor,
  output logic                    err_proto
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int PW        = $clog2(MAX_PENDING + 1);
  localparam int WW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic                  cmd, accept, wr_acc, rd_acc, oor, rsp_valid;
  logic [63:0]           idx;
  logic [WW-1:0]         wcnt_reg;
  logic [PW-1:0]         pending_reg;
  logic [DATA_WIDTH-1:0] wr_count_reg;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] scratch_reg [2:NUM_REGS-1];
  logic                  err_oor_reg, err_proto_reg;

  assign cmd             = avs_read | avs_write;
  assign accept          = cmd && (wcnt_reg == '0) && (pending_reg < PW'(MAX_PENDING)) && rst_n;
  assign avs_waitrequest = !accept;
  assign wr_acc          = accept & avs_write;
  // A read presented together with a write is dropped; only the write takes effect.
  assign rd_acc          = accept & avs_read & ~avs_write;
  assign idx             = word_index(64'(avs_address), LANE_BITS);
  assign oor             = idx >= 64'(NUM_REGS);
  assign err_oor         = err_oor_reg;
  assign err_proto       = err_proto_reg;

  always_comb begin
    rd_word = BAD_DATA;
    if (!oor) begin
      if (idx == 64'(ID_IDX))        rd_word = ID_VALUE;
      else if (idx == 64'(WCNT_IDX)) rd_word = wr_count_reg;
      else begin
        for (int i = 2; i < NUM_REGS; i++)
          if (idx == 64'(i)) rd_word = scratch_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_reg      <= WW'(WAIT_CYCLES);
      pending_reg   <= '0;
      wr_count_reg  <= '0;
      err_oor_reg   <= 1'b0;
      err_proto_reg <= 1'b0;
    end else begin
      if (accept)                         wcnt_reg <= WW'(WAIT_CYCLES);
      else if (cmd && wcnt_reg != '0)     wcnt_reg <= wcnt_reg - 1'b1;

      case ({rd_acc, rsp_valid})
        2'b10:   pending_reg <= pending_reg + 1'b1;
        2'b01:   pending_reg <= pending_reg - 1'b1;
        default: pending_reg <= pending_reg;
      endcase

      if (wr_acc)                      wr_count_reg  <= wr_count_reg + 1'b1;
      if (accept && oor)               err_oor_reg   <= 1'b1;
      if (accept && avs_read && avs_write) err_proto_reg <= 1'b1;
    end
  end

  // RO and out-of-range indices never match a scratch slot, so those writes fall away here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 2; i < NUM_REGS; i++) scratch_reg[i] <= '0;
    end else if (wr_acc) begin
      for (int i = 2; i < NUM_REGS; i++)
        if (idx == 64'(i))
          for (int b = 0; b < LANES; b++)
            if (avs_byteenable[b]) scratch_reg[i][8*b +: 8] <= avs_writedata[8*b +: 8];
    end
  end

  avmm_rd_delay_line #(
    .DEPTH      (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (rsp_valid),
    .out_data  (avs_readdata)
  );

  assign avs_readdatavalid = rsp_valid;

endmodule
